instr_fetch_unit: RTL and testbench

- Upstream neighbour of cpu_19bit.
- Issues sequential fetch addresses to a 19-bit instruction memory and buffers returned words in a small prefetch FIFO.
- Presents {instruction, pc} with a valid/ready handshake to the CPU decode input.
- Handles branch/jump redirects: flushes buffered words and discards in-flight responses from the old stream.

---
 rtl/cpu19_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu19_pkg.sv
// rtl/cpu19_pkg.sv - shared types and constants for the 19-bit CPU fetch path
package cpu19_pkg;
    localparam int XLEN = 19;
    localparam logic [XLEN-1:0] RESET_PC  = 19'h00000;
    localparam logic [XLEN-1:0] NOP_INSTR = 19'h00000;

    typedef enum logic {S_RUN, S_FLUSH} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with flush and occupancy count
module fetch_fifo
    import cpu19_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction fetch with prefetch FIFO and redirect flush
module instr_fetch_unit #(
    parameter int                           DEPTH    = 4,
    parameter logic [cpu19_pkg::XLEN-1:0]   RESET_PC = cpu19_pkg::RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        mem_req,
    output logic [cpu19_pkg::XLEN-1:0]  mem_addr,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [cpu19_pkg::XLEN-1:0]  mem_rdata,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [cpu19_pkg::XLEN-1:0]  instruction,
    output logic [cpu19_pkg::XLEN-1:0]  instr_pc,
    input  logic                        redirect,
    input  logic [cpu19_pkg::XLEN-1:0]  redirect_pc
);
    import cpu19_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] pc_tag;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   outstanding_next;
    logic            fifo_empty;
    logic            grant;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    // Counting buffered plus in-flight words reserves a FIFO slot for every response.
    assign mem_req  = rst_n && (state == S_RUN) && !redirect &&
                      (({1'b0, fifo_count} + {1'b0, outstanding}) < LIMIT);
    assign mem_addr = fetch_addr;
    assign grant    = mem_req && mem_gnt;
    assign push     = mem_rvalid && !redirect && (discard_cnt == '0);
    assign pop      = instr_valid && instr_ready && !redirect;

    assign push_data   = '{pc: pc_tag, instr: mem_rdata};
    assign instr_valid = !fifo_empty;
    assign instruction = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc : '0;

    // On redirect every request still in flight belongs to the old stream.
    assign outstanding_next = outstanding + CW'(grant) - CW'(mem_rvalid);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            fetch_addr  <= RESET_PC;
            pc_tag      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_addr  <= redirect_pc;
                pc_tag      <= redirect_pc;
                discard_cnt <= outstanding_next;
                state       <= (outstanding_next != '0) ? S_FLUSH : S_RUN;
            end else begin
                if (grant) fetch_addr <= fetch_addr + XLEN'(1);
                if (push)  pc_tag     <= pc_tag + XLEN'(1);
                if (mem_rvalid && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
                if ((state == S_FLUSH) && (discard_cnt == '0)) state <= S_RUN;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a latency-configurable memory model
module tb_instr_fetch_unit;
    import cpu19_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] instr_pc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(19'h00000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [XLEN-1:0] data;
        int              due;
    } mem_rsp_t;

    mem_rsp_t        mem_q[$];
    fetch_entry_t    sb_q[$];
    logic [XLEN-1:0] got_pc[$];
    logic [XLEN-1:0] exp_addr;
    int checks = 0;
    int errors = 0;
    int cyc, latency, last_due, grants, outst_model;
    int first_grant_cyc, first_valid_cyc, flush_cycles;
    logic redir_rv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] image(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] m = 19'd37;
        return (a * m) ^ 19'h2A5C3;
    endfunction

    function automatic logic rsp_due();
        return (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instruction", instruction, 0);
        check("rst_instr_pc", instr_pc, 0);
        mem_q.delete();
        sb_q.delete();
        got_pc.delete();
        exp_addr = 19'h00000;
        outst_model = 0;
        grants = 0;
        last_due = -1;
        cyc = 0;
        first_grant_cyc = -1;
        first_valid_cyc = -1;
        flush_cycles = 0;
        redir_rv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs just after the falling edge, observe 1 ns later.
    task automatic step(input logic do_redir, input logic [XLEN-1:0] pc);
        int d;
        redirect = do_redir;
        redirect_pc = pc;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        if (rsp_due()) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
        end
        #1;
        check("outstanding", 32'(dut.outstanding), outst_model);
        check("outst_le_depth", 32'(dut.outstanding <= DEPTH), 1);
        check("fifo_le_depth", 32'(dut.u_fifo.count <= DEPTH), 1);
        if (!instr_valid) begin
            check("idle_instruction", instruction, 0);
            check("idle_instr_pc", instr_pc, 0);
        end
        if (dut.state == S_FLUSH) flush_cycles++;
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (redirect) begin
            check("req_low_on_redirect", mem_req, 0);
            if (mem_rvalid) redir_rv = 1'b1;
            sb_q.delete();
            got_pc.delete();
            exp_addr = pc;
        end
        if (mem_req && mem_gnt) begin
            check("mem_addr", mem_addr, exp_addr);
            d = cyc + latency;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{data: image(mem_addr), due: d});
            sb_q.push_back('{pc: exp_addr, instr: image(exp_addr)});
            exp_addr = exp_addr + 19'd1;
            grants++;
            outst_model++;
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
        end
        if (mem_rvalid) outst_model--;
        if (instr_valid && instr_ready && !redirect) begin
            got_pc.push_back(instr_pc);
            check("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                check("deliver_pc", instr_pc, sb_q[0].pc);
                check("deliver_instr", instruction, sb_q[0].instr);
                void'(sb_q.pop_front());
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_got(input string tag, input logic [XLEN-1:0] e [4]);
        check({tag, "_count"}, 32'(got_pc.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < got_pc.size()) check(tag, got_pc[i], e[i]);
        end
    endtask

    initial begin
        mem_gnt = 1'b1;
        instr_ready = 1'b1;
        redirect_pc = '0;
        latency = 1;

        // Straight-line fetch at 1-cycle latency.
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b0, '0);
        check("first_valid_latency", 32'(first_valid_cyc - first_grant_cyc), 2);
        check_got("seq_pc", '{19'h0, 19'h1, 19'h2, 19'h3});

        // Back-pressure: FIFO fills, then drains in order.
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        check("stall_grants", grants, 4);
        #1;
        check("stall_req_low", mem_req, 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check_got("drain_pc", '{19'h0, 19'h1, 19'h2, 19'h3});

        // Redirect with two stale requests in flight at latency 3.
        latency = 3;
        do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        step(1'b1, 19'h00100);
        for (int i = 0; i < 12; i++) step(1'b0, '0);
        check("flush_cycles_ge2", 32'(flush_cycles >= 2), 1);
        check("redir_first_pc", got_pc.size() > 0 ? got_pc[0] : 19'h7FFFF, 19'h00100);
        check("redir_second_pc", got_pc.size() > 1 ? got_pc[1] : 19'h7FFFF, 19'h00101);

        // Address wrap past the top of the 19-bit space.
        latency = 1;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        step(1'b1, 19'h7FFFE);
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        check_got("wrap_pc", '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001});

        // Redirect coinciding with rvalid, then a second redirect one cycle later.
        latency = 2;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0);
        for (int i = 0; i < 10 && !rsp_due(); i++) step(1'b0, '0);
        step(1'b1, 19'h00200);
        step(1'b1, 19'h00300);
        check("redir_with_rvalid", redir_rv, 1);
        instr_ready = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        check("idle_outstanding", 32'(dut.outstanding), 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check_got("double_redir_pc", '{19'h00300, 19'h00301, 19'h00302, 19'h00303});

        // Reset asserted mid-stream with responses in flight.
        latency = 3;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0);
        check("pre_reset_valid", instr_valid, 1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        check("post_reset_first_pc", got_pc.size() > 0 ? got_pc[0] : 19'h7FFFF, 19'h00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
